// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution pass sequencer.
// Default geometry matches the productor systolic array build.
package conv_pkg;

    localparam int WORDWIDTH   = 32;
    localparam int FIG_WIDTH   = 28;
    localparam int WEIGHTLEN   = 5;
    localparam int ARRAYLEN    = WEIGHTLEN * WEIGHTLEN;
    localparam int FIG_ADDRLEN = 5;

    localparam int OUT_SIDE   = FIG_WIDTH - WEIGHTLEN + 1;
    localparam int OUT_TOTAL  = OUT_SIDE * OUT_SIDE;
    localparam int W_CNT_W    = $clog2(ARRAYLEN);
    localparam int OUT_CNT_W  = $clog2(OUT_TOTAL + 1);
    localparam int MEM_ADDR_W = 2 * FIG_ADDRLEN;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/conv_sequencer_rd_pipe.sv
// Read-return pipeline: two-stage valid/wload delay and the
// data register that turns a memory return into a productor word.
module conv_sequencer_rd_pipe #(
    parameter int WORDWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 rd_w,
    input  logic [WORDWIDTH-1:0] rdata,
    output logic [WORDWIDTH-1:0] din,
    output logic                 valid,
    output logic                 wload
);

    logic v1;
    logic w1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            w1    <= 1'b0;
            valid <= 1'b0;
            wload <= 1'b0;
            din   <= '0;
        end else begin
            v1    <= rd_en;
            w1    <= rd_w;
            valid <= v1;
            wload <= w1;
            if (v1) begin
                din <= rdata;
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one convolution pass: weight load, row-major feature
// stream, then waits for the full output map from the productor.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int WORDWIDTH   = conv_pkg::WORDWIDTH,
    parameter int FIG_WIDTH   = conv_pkg::FIG_WIDTH,
    parameter int WEIGHTLEN   = conv_pkg::WEIGHTLEN,
    parameter int ARRAYLEN    = conv_pkg::ARRAYLEN,
    parameter int FIG_ADDRLEN = conv_pkg::FIG_ADDRLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic                     mem_sel,
    output logic [2*FIG_ADDRLEN-1:0] mem_addr,
    input  logic [WORDWIDTH-1:0]     mem_rdata,
    output logic [WORDWIDTH-1:0]     pe_din,
    output logic                     pe_valid,
    output logic                     pe_wload,
    input  logic                     pe_out_valid
);

    localparam int OUT_N = (FIG_WIDTH - WEIGHTLEN + 1) ** 2;
    localparam int OCW   = $clog2(OUT_N + 1);
    localparam int WCW   = $clog2(ARRAYLEN);
    localparam int AW    = 2 * FIG_ADDRLEN;

    seq_state_t state;
    seq_state_t state_nxt;

    logic [WCW-1:0]         w_cnt;
    logic [FIG_ADDRLEN-1:0] row;
    logic [FIG_ADDRLEN-1:0] col;
    logic [OCW-1:0]         out_cnt;

    logic w_last;
    logic f_last;
    logic col_last;
    logic out_inc;
    logic out_full;

    assign w_last   = w_cnt == WCW'(ARRAYLEN - 1);
    assign col_last = col == FIG_ADDRLEN'(FIG_WIDTH - 1);
    assign f_last   = col_last && row == FIG_ADDRLEN'(FIG_WIDTH - 1);

    // Saturating count; out_full looks ahead so DONE follows the
    // final pulse by one cycle.
    assign out_inc  = pe_out_valid
                   && (state == STREAM || state == DRAIN)
                   && out_cnt != OCW'(OUT_N);
    assign out_full = out_cnt == OCW'(OUT_N)
                   || (out_inc && out_cnt == OCW'(OUT_N - 1));

    assign busy = state == LOAD_W || state == STREAM || state == DRAIN;
    assign done = state == DONE;

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_sel   = 1'b0;
        mem_addr  = '0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                mem_rd_en = !hold;
                mem_addr  = AW'(w_cnt);
                if (!hold && w_last) state_nxt = STREAM;
            end
            STREAM: begin
                mem_rd_en = !hold;
                mem_sel   = 1'b1;
                mem_addr  = {row, col};
                if (!hold && f_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_full) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            w_cnt   <= '0;
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                w_cnt   <= '0;
                row     <= '0;
                col     <= '0;
                out_cnt <= '0;
            end
            if (state == LOAD_W && mem_rd_en) begin
                w_cnt <= w_last ? '0 : w_cnt + 1'b1;
            end
            if (state == STREAM && mem_rd_en) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row + 1'b1;
            end
            if (out_inc) out_cnt <= out_cnt + 1'b1;
        end
    end

    conv_sequencer_rd_pipe #(
        .WORDWIDTH(WORDWIDTH)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .rd_en (mem_rd_en),
        .rd_w  (mem_rd_en & ~mem_sel),
        .rdata (mem_rdata),
        .din   (pe_din),
        .valid (pe_valid),
        .wload (pe_wload)
    );

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: plain pass, hold, mid-pass
// reset, then a fresh pass after the reset.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic        mem_sel;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] pe_din;
    logic        pe_valid;
    logic        pe_wload;
    logic        pe_out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold         (hold),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .pe_din       (pe_din),
        .pe_valid     (pe_valid),
        .pe_wload     (pe_wload),
        .pe_out_valid (pe_out_valid)
    );

    function automatic logic [31:0] dat(logic sel, logic [9:0] a);
        return {sel, 11'h5A3, 10'h2C1, a};
    endfunction

    function automatic logic [9:0] addr_of(int k);
        int f;
        if (k < 25) return 10'(k);
        f = k - 25;
        return {5'(f / 28), 5'(f % 28)};
    endfunction

    always @(posedge clk)
        mem_rdata <= mem_rd_en ? dat(mem_sel, mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: plain pass with a start while busy
    // mode 1: hold in cycles 11..13
    // mode 2: reset coincident with start at cycle 300
    task automatic run_pass(int mode);
        logic        ev [0:2047];
        logic        ew [0:2047];
        logic [31:0] ed [0:2047];
        int          k;
        int          last;
        logic        aborted;
        logic        exp_rd;
        logic        exp_v;
        logic [9:0]  exp_a;
        for (int i = 0; i < 2048; i++) begin
            ev[i] = 1'b0;
            ew[i] = 1'b0;
            ed[i] = '0;
        end
        k    = 0;
        last = (mode == 2) ? 305 : 1362;
        for (int c = 0; c <= last; c++) begin
            start = (c == 0) || (mode == 0 && c == 100)
                 || (mode == 2 && c == 300);
            hold  = (mode == 1) && c >= 11 && c <= 13;
            rst   = (mode == 2) && c == 300;
            pe_out_valid = c == 0 || c == 5
                || (c >= 200 && c <= 1350 && (c - 200) % 2 == 0)
                || c == 1351 || c == 1353;
            aborted = (mode == 2) && c > 300;
            exp_rd  = !aborted && c >= 1 && k < 809 && !hold;
            exp_a   = exp_rd ? addr_of(k) : 10'd0;
            exp_v   = !aborted && ev[c];
            @(negedge clk);
            chk($sformatf("m%0d c%0d rd_en", mode, c), 32'(mem_rd_en), 32'(exp_rd));
            if (exp_rd) begin
                chk($sformatf("m%0d c%0d sel", mode, c), 32'(mem_sel), 32'(k >= 25));
                chk($sformatf("m%0d c%0d addr", mode, c), 32'(mem_addr), 32'(exp_a));
            end
            chk($sformatf("m%0d c%0d pe_valid", mode, c), 32'(pe_valid), 32'(exp_v));
            chk($sformatf("m%0d c%0d pe_wload", mode, c), 32'(pe_wload), 32'(exp_v && ew[c]));
            if (exp_v)
                chk($sformatf("m%0d c%0d pe_din", mode, c), pe_din, ed[c]);
            chk($sformatf("m%0d c%0d busy", mode, c), 32'(busy),
                32'(!aborted && c >= 1 && c <= 1350));
            chk($sformatf("m%0d c%0d done", mode, c), 32'(done),
                32'(!aborted && c == 1351));
            if (mode == 0) begin
                if (c == 26)  chk("spot c26 addr", 32'(mem_addr), 32'd0);
                if (c == 26)  chk("spot c26 sel", 32'(mem_sel), 32'd1);
                if (c == 54)  chk("spot c54 addr", 32'(mem_addr), 32'd32);
                if (c == 809) chk("spot c809 addr", 32'(mem_addr), 32'd891);
                if (c == 810) chk("spot c810 rd_en", 32'(mem_rd_en), 32'd0);
            end
            if (mode == 1 && c == 14)
                chk("hold c14 addr", 32'(mem_addr), 32'd10);
            if (exp_rd) begin
                ev[c+2] = 1'b1;
                ew[c+2] = k < 25;
                ed[c+2] = dat(k >= 25, exp_a);
                k++;
            end
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        hold         = 1'b0;
        rst          = 1'b0;
        pe_out_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        hold         = 1'b0;
        pe_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst pe_valid", 32'(pe_valid), 32'd0);
        chk("rst pe_wload", 32'(pe_wload), 32'd0);
        chk("rst pe_din", pe_din, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("start under rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run_pass(0);
        run_pass(1);
        run_pass(2);
        run_pass(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller that sequences one convolution pass through the productor systolic datapath.
- Owns the single shared weight/feature read port. Issues the ARRAYLEN weight reads (weight-load phase), then the FIG_WIDTH x FIG_WIDTH feature reads (stream phase).
- Forwards the returned words to the productor as din/in_valid.
- Counts productor out_valid pulses and signals done when the full output map has been produced.

Parameters:
- WORDWIDTH, 32, data word width.
- FIG_WIDTH, 28, feature map side length in pixels.
- WEIGHTLEN, 5, kernel side length.
- ARRAYLEN, 25, kernel element count; must equal WEIGHTLEN*WEIGHTLEN.
- FIG_ADDRLEN, 5, bits per feature row/column index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a pass.
- hold  in  1  suspends issuing new reads while high.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at pass completion.
- mem_rd_en  out  1  read strobe on the shared memory port.
- mem_sel  out  1  0 = weight memory, 1 = feature memory.
- mem_addr  out  2*FIG_ADDRLEN  weight: index zero-extended; feature: {row, col}.
- mem_rdata  in  WORDWIDTH  read data, valid exactly one cycle after mem_rd_en.
- pe_din  out  WORDWIDTH  word to productor din.
- pe_valid  out  1  to productor in_valid.
- pe_wload  out  1  high with pe_valid when pe_din is a weight.
- pe_out_valid  in  1  productor out_valid.

Behaviour:
- Reset: state IDLE, all counters 0. busy, done, mem_rd_en, pe_valid, pe_wload = 0; pe_din = 0; pipeline valid bits cleared.
- Reset mid-pass aborts immediately. Data returning after reset is discarded.
- State machine IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at an edge moves to LOAD_W.
- LOAD_W:
  - mem_rd_en = !hold, mem_sel = 0, mem_addr = w_cnt. These are combinational from registered state.
  - w_cnt advances only on an issued read.
  - After the read with w_cnt = ARRAYLEN-1, go to STREAM. The next cycle issues feature {0,0}; there is no bubble.
- STREAM:
  - mem_rd_en = !hold, mem_sel = 1, mem_addr = {row, col}.
  - Scan is row-major: col wraps at FIG_WIDTH-1 and increments row.
  - After the read of {FIG_WIDTH-1, FIG_WIDTH-1}, go to DRAIN.
- DRAIN: no reads. When out_cnt reaches OUT_TOTAL, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done rises.
- Data path:
  - pe_din is mem_rdata registered once, so pe_din is visible 2 cycles after mem_rd_en.
  - pe_valid and pe_wload follow a 2-stage delay of mem_rd_en and (mem_rd_en & !mem_sel).
- hold:
  - Freezes counters and suppresses mem_rd_en.
  - Reads already in flight still complete, so pe_valid may show gaps.
  - hold has no effect in IDLE, DRAIN or DONE.
- out_cnt:
  - Increments on pe_out_valid in STREAM and DRAIN; it may legally begin before streaming ends.
  - pe_out_valid is ignored in IDLE, LOAD_W and DONE.
  - Pulses beyond OUT_TOTAL are ignored (saturate).
- Out-of-state start: ignored while busy; no restart. start coincident with rst: reset wins.
- Width rules:
  - OUT_TOTAL = (FIG_WIDTH-WEIGHTLEN+1)^2 = 576.
  - out_cnt width = clog2(OUT_TOTAL+1).
  - w_cnt width = clog2(ARRAYLEN).
  - Weight address is zero-extended to 2*FIG_ADDRLEN bits.
- Minimum pass length with hold=0: 1 + ARRAYLEN + FIG_WIDTH^2 cycles of issue, plus drain, plus 1 for DONE.

Decomposition:
- Shared package conv_pkg holds:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE);
  - localparams OUT_SIDE = FIG_WIDTH-WEIGHTLEN+1, OUT_TOTAL, W_CNT_W, OUT_CNT_W, MEM_ADDR_W = 2*FIG_ADDRLEN.
- One natural sub-module: rd_pipe, the 2-stage valid/wload delay plus data register. The FSM and counters stay in conv_sequencer.

Test Plan:
- Weight load:
  - Stimulus: start at cycle 0, hold=0.
  - Response: cycles 1..25 show mem_rd_en=1, mem_sel=0, mem_addr 0..24. pe_valid=pe_wload=1 in cycles 3..27 with pe_din equal to the memory contents at addresses 0..24.
- Feature stream:
  - Response: cycle 26 issues {0,0}, cycle 54 issues {1,0}, cycle 809 issues {27,27}.
  - pe_wload=0 for all 784 words.
  - mem_rd_en is 0 from cycle 810.
- Completion:
  - Stimulus: model productor pulses pe_out_valid 576 times starting at cycle 200.
  - Response: done is high for exactly one cycle, the cycle after the 576th counted pulse. busy=0 in that cycle; state returns to IDLE. A 577th pulse does not change anything.
- Hold:
  - Stimulus: hold=1 in cycles 11..13 (w_cnt=10).
  - Response: no reads issued in cycles 11..13. Address 10 is issued in cycle 14, with no address skipped or repeated. Every later address is shifted by +3 cycles. pe_valid gap of 3 cycles.
- Start while busy:
  - Stimulus: start pulse at cycle 100.
  - Response: no change in address sequence or counters.
- Reset mid-stream:
  - Stimulus: rst=1 at cycle 300 for 1 cycle.
  - Response: next cycle busy=0, mem_rd_en=0, pe_valid=0, even though reads were in flight. A new start runs a full pass from weight address 0.
